// File: rtl/bias_buffer_loader.sv
// Bias buffer write-side feeder: scatters a valid/ready word stream
// across BUFFER_NUM bias banks, bank-interleaved from a base row address.
module bias_buffer_loader #(
    parameter int X_PE       = 16,
    parameter int ADDR_LEN   = 9,
    parameter int DATA_LEN   = 64,
    parameter int BUFFER_NUM = 8 * X_PE / DATA_LEN,
    parameter int CNT_LEN    = ADDR_LEN + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ld_conf,
    input  logic [ADDR_LEN-1:0]   ld_base_addr,
    input  logic [CNT_LEN-1:0]    ld_rows,
    input  logic [DATA_LEN-1:0]   din,
    input  logic                  din_valid,
    output logic                  din_ready,
    output logic [DATA_LEN-1:0]   data_wr,
    output logic [ADDR_LEN-1:0]   wr_addr,
    output logic [BUFFER_NUM-1:0] wr_en,
    output logic                  done,
    output logic                  idle
);

    localparam int BANK_W = (BUFFER_NUM > 1) ? $clog2(BUFFER_NUM) : 1;
    localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(BUFFER_NUM - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_LEN-1:0]   addr_cnt_q, addr_cnt_d;
    logic [CNT_LEN-1:0]    rows_left_q, rows_left_d;
    logic [BANK_W-1:0]     bank_cnt_q, bank_cnt_d;
    logic [DATA_LEN-1:0]   data_wr_q, data_wr_d;
    logic [ADDR_LEN-1:0]   wr_addr_q, wr_addr_d;
    logic [BUFFER_NUM-1:0] wr_en_q, wr_en_d;
    logic                  done_q, done_d;
    logic                  idle_q, idle_d;
    logic                  accept;

    assign din_ready = (state_q == LOAD);
    assign accept    = din_valid && din_ready;
    assign data_wr   = data_wr_q;
    assign wr_addr   = wr_addr_q;
    assign wr_en     = wr_en_q;
    assign done      = done_q;
    assign idle      = idle_q;

    always_comb begin
        state_d     = state_q;
        addr_cnt_d  = addr_cnt_q;
        rows_left_d = rows_left_q;
        bank_cnt_d  = bank_cnt_q;
        data_wr_d   = data_wr_q;
        wr_addr_d   = wr_addr_q;
        wr_en_d     = '0;
        unique case (state_q)
            IDLE: begin
                if (ld_conf) begin
                    addr_cnt_d  = ld_base_addr;
                    rows_left_d = ld_rows;
                    bank_cnt_d  = '0;
                    state_d     = (ld_rows == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (accept) begin
                    data_wr_d = din;
                    wr_addr_d = addr_cnt_q;
                    wr_en_d   = BUFFER_NUM'(1) << bank_cnt_q;
                    if (bank_cnt_q == LAST_BANK) begin
                        bank_cnt_d  = '0;
                        addr_cnt_d  = addr_cnt_q + 1'b1;
                        rows_left_d = rows_left_q - 1'b1;
                        if (rows_left_q == CNT_LEN'(1)) begin
                            state_d = DONE;
                        end
                    end else begin
                        bank_cnt_d = bank_cnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // done/idle are registered from the next state so they line up
        // with the final registered write
        done_d = (state_d == DONE);
        idle_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_cnt_q  <= '0;
            rows_left_q <= '0;
            bank_cnt_q  <= '0;
            data_wr_q   <= '0;
            wr_addr_q   <= '0;
            wr_en_q     <= '0;
            done_q      <= 1'b0;
            idle_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            addr_cnt_q  <= addr_cnt_d;
            rows_left_q <= rows_left_d;
            bank_cnt_q  <= bank_cnt_d;
            data_wr_q   <= data_wr_d;
            wr_addr_q   <= wr_addr_d;
            wr_en_q     <= wr_en_d;
            done_q      <= done_d;
            idle_q      <= idle_d;
        end
    end

endmodule

// File: tb/tb_bias_buffer_loader.sv
// Directed self-checking bench for bias_buffer_loader.
// Scenario tasks drive stimulus and compare against hand-derived writes.
module tb_bias_buffer_loader;

    localparam int AL = 9;
    localparam int DL = 64;
    localparam int BN = 2;
    localparam int CL = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          ld_conf;
    logic [AL-1:0] ld_base_addr;
    logic [CL-1:0] ld_rows;
    logic [DL-1:0] din;
    logic          din_valid;
    logic          din_ready;
    logic [DL-1:0] data_wr;
    logic [AL-1:0] wr_addr;
    logic [BN-1:0] wr_en;
    logic          done;
    logic          idle;

    bias_buffer_loader dut (
        .clk          (clk),
        .rst          (rst),
        .ld_conf      (ld_conf),
        .ld_base_addr (ld_base_addr),
        .ld_rows      (ld_rows),
        .din          (din),
        .din_valid    (din_valid),
        .din_ready    (din_ready),
        .data_wr      (data_wr),
        .wr_addr      (wr_addr),
        .wr_en        (wr_en),
        .done         (done),
        .idle         (idle)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AL-1:0] addr;
        logic [BN-1:0] en;
        logic [DL-1:0] data;
        logic          dn;
    } wr_t;

    wr_t        writes[$];
    int         done_cnt = 0;
    int         rdy_cnt  = 0;
    int         acc_cnt  = 0;
    int         lat_err  = 0;
    logic       prev_acc = 1'b0;
    int         checks   = 0;
    int         errors   = 0;
    logic [DL-1:0] words[8];

    // write log plus a latency tracker: a write must follow every accept
    always @(negedge clk) begin
        if (wr_en != '0) writes.push_back({wr_addr, wr_en, data_wr, done});
        if (done === 1'b1) done_cnt++;
        if (din_ready === 1'b1) rdy_cnt++;
        if ((wr_en != '0) != prev_acc) lat_err++;
        prev_acc = din_valid && din_ready;
        if (prev_acc) acc_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic fill_words(input logic [15:0] tag);
        for (int i = 0; i < 8; i++) begin
            words[i] = {16'hB1A5, tag, 32'(i) * 32'h1111_1111 + 32'h0F0F_0001};
        end
    endtask

    task automatic start_load(input logic [AL-1:0] base, input logic [CL-1:0] rows);
        ld_base_addr = base;
        ld_rows      = rows;
        ld_conf      = 1'b1;
        @(posedge clk); #1;
        ld_conf = 1'b0;
    endtask

    task automatic send_words(input int n, input bit bubbles, input int conf_at);
        int sent;
        int ph;
        bit acc;
        sent = 0;
        ph   = 0;
        while (sent < n && ph < 100) begin
            din       = words[sent];
            din_valid = bubbles ? (ph % 3 == 0) : 1'b1;
            if (ph == conf_at) begin
                ld_conf      = 1'b1;
                ld_base_addr = 9'h100;
                ld_rows      = 10'd5;
            end
            @(negedge clk);
            acc = din_valid && din_ready;
            @(posedge clk); #1;
            ld_conf = 1'b0;
            if (acc) sent++;
            ph++;
        end
        din_valid = 1'b0;
        checks++;
        if (sent != n) begin
            errors++;
            $display("FAIL send_words accepted %0d required %0d", sent, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ld_conf = 1'b0;
        ld_base_addr = '0;
        ld_rows = '0;
        din = '0;
        din_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle got %b required 1", idle); end
        checks++;
        if (din_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b required 0", din_ready); end
        checks++;
        if (wr_en !== 2'b00) begin errors++; $display("FAIL reset_wr_en got %b required 00", wr_en); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b required 0", done); end
        checks++;
        if (data_wr !== 64'h0) begin errors++; $display("FAIL reset_data got %h required 0", data_wr); end
        checks++;
        if (wr_addr !== 9'h0) begin errors++; $display("FAIL reset_addr got %h required 0", wr_addr); end
    endtask

    task automatic test_basic_load();
        int wb, db, lb;
        fill_words(16'h0001);
        wb = writes.size();
        db = done_cnt;
        lb = lat_err;
        start_load(9'h010, 10'd3);
        checks++;
        if (idle !== 1'b0 || din_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_start idle=%b ready=%b required idle=0 ready=1", idle, din_ready);
        end
        send_words(6, 1'b0, -1);
        checks++;
        if (done !== 1'b1 || wr_en !== 2'b10 || wr_addr !== 9'h012 || data_wr !== words[5]) begin
            errors++;
            $display("FAIL basic_last done=%b en=%b addr=%h data=%h required 1 10 012 %h", done, wr_en, wr_addr, data_wr, words[5]);
        end
        @(posedge clk); #1;
        checks++;
        if (idle !== 1'b1 || done !== 1'b0 || wr_en !== 2'b00 || din_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_after idle=%b done=%b en=%b ready=%b required 1 0 00 0", idle, done, wr_en, din_ready);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (writes.size() - wb != 6) begin
            errors++;
            $display("FAIL basic_count got %0d required 6", writes.size() - wb);
        end
        for (int i = 0; i < 6; i++) begin
            wr_t e, g;
            e = {9'h010 + 9'(i / 2), (i % 2 == 1) ? 2'b10 : 2'b01, words[i], i == 5};
            g = (wb + i < writes.size()) ? writes[wb + i] : '0;
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL basic_wr%0d got %h/%b/%h/%b required %h/%b/%h/%b", i, g.addr, g.en, g.data, g.dn, e.addr, e.en, e.data, e.dn);
            end
        end
        checks++;
        if (done_cnt - db != 1) begin errors++; $display("FAIL basic_done_cnt got %0d required 1", done_cnt - db); end
        checks++;
        if (lat_err != lb) begin errors++; $display("FAIL basic_latency got %0d errors required 0", lat_err - lb); end
    endtask

    task automatic test_bubbles();
        int wb, ab, lb;
        fill_words(16'h0002);
        wb = writes.size();
        ab = acc_cnt;
        lb = lat_err;
        start_load(9'h010, 10'd3);
        send_words(6, 1'b1, -1);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (acc_cnt - ab != 6) begin errors++; $display("FAIL bub_accepts got %0d required 6", acc_cnt - ab); end
        checks++;
        if (lat_err != lb) begin errors++; $display("FAIL bub_gap_wr_en got %0d errors required 0", lat_err - lb); end
        checks++;
        if (writes.size() - wb != 6) begin errors++; $display("FAIL bub_count got %0d required 6", writes.size() - wb); end
        for (int i = 0; i < 6; i++) begin
            wr_t e, g;
            e = {9'h010 + 9'(i / 2), (i % 2 == 1) ? 2'b10 : 2'b01, words[i], i == 5};
            g = (wb + i < writes.size()) ? writes[wb + i] : '0;
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL bub_wr%0d got %h/%b/%h/%b required %h/%b/%h/%b", i, g.addr, g.en, g.data, g.dn, e.addr, e.en, e.data, e.dn);
            end
        end
    endtask

    task automatic test_addr_wrap();
        int wb;
        logic [AL-1:0] exp_addr[4];
        exp_addr = '{9'h1FF, 9'h1FF, 9'h000, 9'h000};
        fill_words(16'h0003);
        wb = writes.size();
        start_load(9'h1FF, 10'd2);
        send_words(4, 1'b0, -1);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (writes.size() - wb != 4) begin errors++; $display("FAIL wrap_count got %0d required 4", writes.size() - wb); end
        for (int i = 0; i < 4; i++) begin
            wr_t e, g;
            e = {exp_addr[i], (i % 2 == 1) ? 2'b10 : 2'b01, words[i], i == 3};
            g = (wb + i < writes.size()) ? writes[wb + i] : '0;
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL wrap_wr%0d got %h/%b/%h/%b required %h/%b/%h/%b", i, g.addr, g.en, g.data, g.dn, e.addr, e.en, e.data, e.dn);
            end
        end
    endtask

    task automatic test_zero_rows();
        int wb, db, rb;
        wb = writes.size();
        db = done_cnt;
        rb = rdy_cnt;
        start_load(9'h055, 10'd0);
        checks++;
        if (done !== 1'b1 || idle !== 1'b0 || din_ready !== 1'b0) begin
            errors++;
            $display("FAIL zero_done done=%b idle=%b ready=%b required 1 0 0", done, idle, din_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || idle !== 1'b1) begin
            errors++;
            $display("FAIL zero_after done=%b idle=%b required 0 1", done, idle);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (done_cnt - db != 1) begin errors++; $display("FAIL zero_done_cnt got %0d required 1", done_cnt - db); end
        checks++;
        if (writes.size() != wb) begin errors++; $display("FAIL zero_writes got %0d required 0", writes.size() - wb); end
        checks++;
        if (rdy_cnt != rb) begin errors++; $display("FAIL zero_ready got %0d cycles required 0", rdy_cnt - rb); end
    endtask

    task automatic test_reset_mid_load();
        int wb, db;
        fill_words(16'h0004);
        db = done_cnt;
        start_load(9'h030, 10'd3);
        send_words(3, 1'b0, -1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (wr_en !== 2'b00 || din_ready !== 1'b0 || idle !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid en=%b ready=%b idle=%b done=%b required 00 0 1 0", wr_en, din_ready, idle, done);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (done_cnt != db) begin errors++; $display("FAIL rst_mid_done got %0d pulses required 0", done_cnt - db); end
        fill_words(16'h0005);
        wb = writes.size();
        start_load(9'h020, 10'd1);
        send_words(2, 1'b0, -1);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (writes.size() - wb != 2) begin errors++; $display("FAIL rst_reload_count got %0d required 2", writes.size() - wb); end
        for (int i = 0; i < 2; i++) begin
            wr_t e, g;
            e = {9'h020, (i == 1) ? 2'b10 : 2'b01, words[i], i == 1};
            g = (wb + i < writes.size()) ? writes[wb + i] : '0;
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL rst_reload_wr%0d got %h/%b/%h/%b required %h/%b/%h/%b", i, g.addr, g.en, g.data, g.dn, e.addr, e.en, e.data, e.dn);
            end
        end
    endtask

    task automatic test_conf_while_busy();
        int wb, db;
        fill_words(16'h0006);
        wb = writes.size();
        db = done_cnt;
        start_load(9'h040, 10'd2);
        send_words(4, 1'b0, 1);
        ld_conf      = 1'b1;
        ld_base_addr = 9'h100;
        ld_rows      = 10'd1;
        @(posedge clk); #1;
        ld_conf = 1'b0;
        checks++;
        if (idle !== 1'b1 || din_ready !== 1'b0) begin
            errors++;
            $display("FAIL busy_done_conf idle=%b ready=%b required 1 0", idle, din_ready);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (writes.size() - wb != 4) begin errors++; $display("FAIL busy_count got %0d required 4", writes.size() - wb); end
        for (int i = 0; i < 4; i++) begin
            wr_t e, g;
            e = {9'h040 + 9'(i / 2), (i % 2 == 1) ? 2'b10 : 2'b01, words[i], i == 3};
            g = (wb + i < writes.size()) ? writes[wb + i] : '0;
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL busy_wr%0d got %h/%b/%h/%b required %h/%b/%h/%b", i, g.addr, g.en, g.data, g.dn, e.addr, e.en, e.data, e.dn);
            end
        end
        checks++;
        if (done_cnt - db != 1) begin errors++; $display("FAIL busy_done_cnt got %0d required 1", done_cnt - db); end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_bubbles();
        test_addr_wrap();
        test_zero_rows();
        test_reset_mid_load();
        test_conf_while_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bias_buffer_loader.md
Name: bias_buffer_loader

Overview:
- Write-side feeder for the per-PE bias buffer banks.
- Accepts a valid/ready stream of DATA_LEN-bit words from the DMA/DDR read path.
- Scatters the words across BUFFER_NUM bias RAM banks, bank-interleaved, starting at a configured base address, and drives the banks' data_wr / wr_addr / wr_en write port.
- Signals completion so the layer controller can issue the bias read configuration.

Parameters:
- X_PE, 16, number of PEs; 8-bit bias per PE per address.
- ADDR_LEN, 9, bias RAM address width.
- DATA_LEN, 64, stream word and bank data width.
- BUFFER_NUM, 8*X_PE/DATA_LEN (=2), number of banks, i.e. words per address row.
- CNT_LEN, ADDR_LEN+1, width of the row-count field.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- ld_conf  in  1  start pulse; sampled only in IDLE.
- ld_base_addr  in  ADDR_LEN  first row address; captured on ld_conf.
- ld_rows  in  CNT_LEN  number of address rows to fill; captured on ld_conf.
- din  in  DATA_LEN  stream data word.
- din_valid  in  1  stream word valid.
- din_ready  out  1  loader accepts a word this cycle.
- data_wr  out  DATA_LEN  bank write data.
- wr_addr  out  ADDR_LEN  bank write address.
- wr_en  out  BUFFER_NUM  one-hot bank write enable.
- done  out  1  one-cycle completion pulse.
- idle  out  1  high in IDLE.

Behaviour:
- State machine: IDLE, LOAD, DONE.
- Reset values: state IDLE; din_ready 0; wr_en 0; data_wr 0; wr_addr 0; done 0; idle 1. Internal counters are cleared.
- Reset mid-load: on the next edge, all of the above reset values apply. Partial writes already issued stay in RAM. No done pulse is generated.
- IDLE:
  - On ld_conf, capture base address into addr_cnt, ld_rows into rows_left, and set bank_cnt to 0.
  - If ld_rows==0, go to DONE. Otherwise go to LOAD.
  - ld_conf outside IDLE is ignored.
- LOAD:
  - din_ready=1 combinationally whenever state==LOAD.
  - A word is accepted on a cycle with din_valid && din_ready.
  - Registered write, 1-cycle latency from acceptance: next cycle data_wr=din, wr_addr=addr_cnt, wr_en=(1<<bank_cnt). Exactly one bit is set, for one cycle per accepted word.
  - wr_en is 0 on every cycle following a non-accept cycle. data_wr and wr_addr hold their last values.
- Ordering: row r, bank b receives stream word r*BUFFER_NUM+b. Bank 0 is written first, then bank 1, and so on.
- Counter update on accept:
  - If bank_cnt==BUFFER_NUM-1: bank_cnt←0, addr_cnt←addr_cnt+1 (mod 2^ADDR_LEN; 511 wraps to 0), rows_left←rows_left-1.
  - Otherwise: bank_cnt←bank_cnt+1.
- LOAD→DONE happens on acceptance of the final word (last bank while rows_left==1). din_ready drops the following cycle.
- DONE lasts one cycle with done=1, then returns to IDLE.
  - After a nonzero load, the final word's wr_en is asserted in the same cycle as done.
  - ld_conf arriving in DONE is ignored.
- Bubbles: din_valid low stalls with no state change. No timeout.
- idle = (state==IDLE). It is low from the cycle after ld_conf through the DONE cycle.
- Max ld_rows = 2^ADDR_LEN; larger values wrap and overwrite earlier rows. Supplying such values is the controller's responsibility.
- Stream words presented while not ready are not consumed. The loader never drops or duplicates words.

Test Plan:
- Basic load, default params:
  - Stimulus: ld_conf with base=0x010, rows=3; 6 back-to-back valid words W0..W5.
  - Required response: writes in order (addr 0x010, wr_en 01, W0), (0x010, 10, W1), (0x011, 01, W2), (0x011, 10, W3), (0x012, 01, W4), (0x012, 10, W5), each one cycle after acceptance. done is coincident with the W5 write. idle returns to 1 the next cycle.
- Bubbles:
  - Stimulus: same load with din_valid toggling 1,0,0,1,…
  - Required response: identical write sequence. wr_en is 0 in gap cycles. Total accepted words = 6.
- Address wrap:
  - Stimulus: base=0x1FF, rows=2, 4 words.
  - Required response: rows written at 0x1FF then 0x000.
- Zero rows:
  - Stimulus: ld_conf with rows=0.
  - Required response: no wr_en. din_ready never asserts. done pulses exactly once, one cycle after ld_conf.
- Reset mid-load:
  - Stimulus: assert rst after 3 accepted words.
  - Required response: next cycle wr_en=0, din_ready=0, idle=1, no done. A new ld_conf (base=0x020, rows=1) then writes correctly from bank 0.
- ld_conf while busy:
  - Stimulus: pulse ld_conf with base=0x100 during LOAD.
  - Required response: ignored; original addresses continue unchanged.
